// File: rtl/demux_pkg.sv
// Shared types and constants for the 1-to-4 stream demultiplexer.
// Optional feature macro used by this slice: DEMUX_STATS_EN (per-channel pop counters).
package demux_pkg;
  localparam int WIDTH_DEF  = 4;
  localparam int NCH        = 4;
  localparam int FIFO_DEPTH = 2;

  typedef logic [1:0]           chan_sel_t;
  typedef logic [WIDTH_DEF-1:0] word_t;
endpackage

// File: rtl/demux_if.sv
// Handshake bundle between one stimulus source and the four channel sinks of demux1x4_stream.
// stat_cnt is present only when DEMUX_STATS_EN is defined.
interface demux_if #(
  parameter int WIDTH = 4
) (
  input logic clk
);
  import demux_pkg::*;

  logic [WIDTH-1:0]     in_data;
  chan_sel_t            in_sel;
  logic                 in_valid;
  logic                 in_ready;
  logic [NCH*WIDTH-1:0] out_data;
  logic [NCH-1:0]       out_valid;
  logic [NCH-1:0]       out_ready;
`ifdef DEMUX_STATS_EN
  logic [8*NCH-1:0]     stat_cnt;
`endif

  modport source (
    input  clk,
    output in_data, in_sel, in_valid,
    input  in_ready
  );

  modport sink (
    input  clk,
    input  out_data, out_valid,
    output out_ready
  );
endinterface

// File: rtl/demux_chan_fifo.sv
// One channel's 2-entry FIFO; head reads as 0 while empty so storage is never exposed.
module demux_chan_fifo #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             valid,
  output logic             full
);
  logic [WIDTH-1:0] mem [2];
  logic [1:0]       count;
  logic             wr_ptr;
  logic             rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign valid   = (count != 2'd0);
  assign full    = (count == 2'd2);
  assign do_push = push && !full;
  assign do_pop  = pop && valid;
  assign head    = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset: it is only observable through head, which is masked by valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= data;
  end
endmodule

// File: rtl/demux1x4_stream.sv
// Registered 1-to-4 demultiplexer: routes each accepted word into a per-channel 2-entry FIFO.
// Define DEMUX_STATS_EN to add per-channel 8-bit delivered counters on stat_cnt.
module demux1x4_stream
  import demux_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     in_data,
  input  chan_sel_t            in_sel,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [NCH*WIDTH-1:0] out_data,
  output logic [NCH-1:0]       out_valid,
  input  logic [NCH-1:0]       out_ready
`ifdef DEMUX_STATS_EN
  ,
  output logic [8*NCH-1:0]     stat_cnt
`endif
);
  logic [NCH-1:0] push;
  logic [NCH-1:0] pop;
  logic [NCH-1:0] full;

  if (DEPTH != FIFO_DEPTH) begin : g_bad_depth
    $error("demux1x4_stream supports only DEPTH == 2");
  end

  // in_ready looks only at registered fullness, so no path exists from out_ready.
  assign in_ready = !full[in_sel];
  assign pop      = out_valid & out_ready;

  for (genvar k = 0; k < NCH; k++) begin : g_chan
    assign push[k] = in_valid && in_ready && (in_sel == chan_sel_t'(k));

    demux_chan_fifo #(
      .WIDTH(WIDTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push[k]),
      .data  (in_data),
      .pop   (pop[k]),
      .head  (out_data[k*WIDTH +: WIDTH]),
      .valid (out_valid[k]),
      .full  (full[k])
    );
  end

`ifdef DEMUX_STATS_EN
  logic [NCH-1:0][7:0] stat_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_q <= '0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (pop[k]) stat_q[k] <= stat_q[k] + 8'd1;
      end
    end
  end

  assign stat_cnt = stat_q;
`endif
endmodule

// File: tb/tb_demux1x4_stream.sv
// Directed self-checking bench for demux1x4_stream, driven through demux_if.
module tb_demux1x4_stream;
  import demux_pkg::*;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  demux_if #(.WIDTH(4)) bus (.clk(clk));

  demux1x4_stream #(.WIDTH(4), .DEPTH(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (bus.in_data),
    .in_sel    (bus.in_sel),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .out_data  (bus.out_data),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready)
`ifdef DEMUX_STATS_EN
    ,
    .stat_cnt  (bus.stat_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] sel, input logic [3:0] d, input logic [3:0] rdy);
    bus.in_valid  = v;
    bus.in_sel    = sel;
    bus.in_data   = d;
    bus.out_ready = rdy;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    drive(1'b0, 2'd0, 4'h0, 4'b0000);
    tick();
    tick();
    check("rst_out_valid", 32'(bus.out_valid), 32'h0);
    check("rst_out_data", 32'(bus.out_data), 32'h0);
    check("rst_in_ready", 32'(bus.in_ready), 32'h1);
`ifdef DEMUX_STATS_EN
    check("rst_stat_cnt", bus.stat_cnt, 32'h0);
`endif
    rst = 1'b0;

    // Routing: one word per channel, all consumers ready.
    drive(1'b1, 2'd0, 4'hA, 4'b1111);
    #1 check("route_ready", 32'(bus.in_ready), 32'h1);
    tick();
    check("route0_valid", 32'(bus.out_valid), 32'h1);
    check("route0_data", 32'(bus.out_data), 32'h000A);
    drive(1'b1, 2'd1, 4'h5, 4'b1111);
    tick();
    check("route1_valid", 32'(bus.out_valid), 32'h2);
    check("route1_data", 32'(bus.out_data), 32'h0050);
    drive(1'b1, 2'd2, 4'h3, 4'b1111);
    tick();
    check("route2_valid", 32'(bus.out_valid), 32'h4);
    check("route2_data", 32'(bus.out_data), 32'h0300);
    drive(1'b1, 2'd3, 4'hC, 4'b1111);
    tick();
    check("route3_valid", 32'(bus.out_valid), 32'h8);
    check("route3_data", 32'(bus.out_data), 32'hC000);
    bus.in_valid  = 1'b0;
    bus.in_sel    = 2'bxx;
    bus.in_data   = 4'bxxxx;
    tick();
    check("route_drain_valid", 32'(bus.out_valid), 32'h0);
    check("route_drain_data", 32'(bus.out_data), 32'h0);

    // Backpressure on channel 1.
    drive(1'b1, 2'd1, 4'h1, 4'b0000);
    tick();
    check("bp_first_data", 32'(bus.out_data), 32'h0010);
    drive(1'b1, 2'd1, 4'h2, 4'b0000);
    tick();
    drive(1'b0, 2'd1, 4'h0, 4'b0000);
    #1 check("bp_full_ready_sel1", 32'(bus.in_ready), 32'h0);
    bus.in_sel = 2'd0;
    #1 check("bp_ready_sel0", 32'(bus.in_ready), 32'h1);
    drive(1'b1, 2'd1, 4'hF, 4'b0000);
    tick();
    check("bp_blocked_valid", 32'(bus.out_valid), 32'h2);
    check("bp_blocked_head", 32'(bus.out_data), 32'h0010);
    drive(1'b0, 2'd1, 4'h0, 4'b0010);
    tick();
    check("bp_pop1_head", 32'(bus.out_data), 32'h0020);
    tick();
    check("bp_pop2_valid", 32'(bus.out_valid), 32'h0);
    bus.out_ready = 4'b0000;
    #1 check("bp_ready_back", 32'(bus.in_ready), 32'h1);

    // Simultaneous push and pop on channel 3 at count 1.
    drive(1'b1, 2'd3, 4'h7, 4'b0000);
    tick();
    check("sim_hold7", 32'(bus.out_data), 32'h7000);
    drive(1'b1, 2'd3, 4'h8, 4'b1000);
    #1 check("sim_ready", 32'(bus.in_ready), 32'h1);
    tick();
    check("sim_valid", 32'(bus.out_valid), 32'h8);
    check("sim_head8", 32'(bus.out_data), 32'h8000);
    drive(1'b0, 2'd3, 4'h0, 4'b0000);
    tick();
    check("sim_hold8", 32'(bus.out_data), 32'h8000);
    check("sim_count1_ready", 32'(bus.in_ready), 32'h1);
    bus.out_ready = 4'b1000;
    tick();
    check("sim_empty", 32'(bus.out_valid), 32'h0);

    // Pointer wrap on channel 0.
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 2'd0, 4'(i), 4'b0000);
      tick();
      check($sformatf("wrap_head%0d", i), 32'(bus.out_data), 32'(i));
      drive(1'b0, 2'd0, 4'h0, 4'b0001);
      tick();
      check($sformatf("wrap_empty%0d", i), 32'(bus.out_valid), 32'h0);
    end

    // Asynchronous reset with two words buffered on channel 2.
    drive(1'b1, 2'd2, 4'h9, 4'b0000);
    tick();
    drive(1'b1, 2'd2, 4'h6, 4'b0000);
    tick();
    drive(1'b0, 2'd2, 4'h0, 4'b0000);
    #1 check("pre_rst_full", 32'(bus.in_ready), 32'h0);
    #2 rst = 1'b1;
    #1;
    check("arst_out_valid", 32'(bus.out_valid), 32'h0);
    check("arst_out_data", 32'(bus.out_data), 32'h0);
    check("arst_in_ready", 32'(bus.in_ready), 32'h1);
    tick();
    rst = 1'b0;
    #1 check("post_rst_valid", 32'(bus.out_valid), 32'h0);
    drive(1'b1, 2'd2, 4'hB, 4'b0000);
    tick();
    check("post_rst_head", 32'(bus.out_data), 32'h0B00);
    drive(1'b0, 2'd0, 4'h0, 4'b0000);
    #2 rst = 1'b1;
    tick();
    rst = 1'b0;
    #1 check("rst2_valid", 32'(bus.out_valid), 32'h0);

    // Stream 257 words through channel 2.
    for (int i = 0; i < 257; i++) begin
      drive(1'b1, 2'd2, 4'(i), 4'b0100);
      tick();
    end
    drive(1'b0, 2'd0, 4'h0, 4'b0100);
    tick();
    check("stream_empty", 32'(bus.out_valid), 32'h0);
`ifdef DEMUX_STATS_EN
    check("stat_257", bus.stat_cnt, 32'h0001_0000);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
